// File: rtl/ctrl_pipe_decoder_if.sv
// Bus between the instruction register / hazard unit (master) and the
// pipelined control decoder (slave).
interface ctrl_pipe_decoder_if #(
  parameter int ILL_CNT_W = 8
);
  logic                 id_valid;
  logic [6:0]           op;
  logic                 stall;
  logic                 flush;
  logic [2:0]           id_imm_src;
  logic                 ex_valid;
  logic [1:0]           ex_alu_op;
  logic                 ex_alu_a_pc;
  logic                 ex_alu_b_imm;
  logic                 ex_branch;
  logic                 ex_jump;
  logic                 ex_jalr;
  logic                 ex_illegal;
  logic                 mem_valid;
  logic                 mem_write;
  logic                 mem_read;
  logic                 wb_valid;
  logic                 wb_reg_write;
  logic [1:0]           wb_result_src;
  logic [ILL_CNT_W-1:0] ill_count;

  modport master (
    output id_valid, op, stall, flush,
    input  id_imm_src, ex_valid, ex_alu_op, ex_alu_a_pc, ex_alu_b_imm,
           ex_branch, ex_jump, ex_jalr, ex_illegal, mem_valid, mem_write,
           mem_read, wb_valid, wb_reg_write, wb_result_src, ill_count
  );

  modport slave (
    input  id_valid, op, stall, flush,
    output id_imm_src, ex_valid, ex_alu_op, ex_alu_a_pc, ex_alu_b_imm,
           ex_branch, ex_jump, ex_jalr, ex_illegal, mem_valid, mem_write,
           mem_read, wb_valid, wb_reg_write, wb_result_src, ill_count
  );
endinterface

// File: rtl/ctrl_pipe_decoder.sv
// RV32I main-control decoder: decodes the opcode in ID and carries the control
// bundle through ID/EX, EX/MEM and MEM/WB with stall, flush and bubble handling.
module ctrl_pipe_decoder #(
  parameter bit EN_JALR   = 1'b1,
  parameter bit EN_AUIPC  = 1'b1,
  parameter int ILL_CNT_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  ctrl_pipe_decoder_if.slave bus
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic       valid;
    logic [1:0] alu_op;
    logic       a_pc;
    logic       b_imm;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       illegal;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic [1:0] res_src;
  } ex_ctrl_t;

  typedef struct packed {
    logic       valid;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic [1:0] res_src;
  } mem_ctrl_t;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [1:0] res_src;
  } wb_ctrl_t;

  ex_ctrl_t             dec;
  logic [2:0]           imm_src;
  ex_ctrl_t             ex_q;
  mem_ctrl_t            mem_q;
  wb_ctrl_t             wb_q;
  logic [ILL_CNT_W-1:0] ill_cnt_q;

  // An illegal opcode decodes to a bundle with only the illegal bit set, so it
  // travels as a bubble that still flags EX for one cycle.
  always_comb begin
    dec     = '0;
    imm_src = 3'b000;
    case (bus.op)
      OP_R: begin
        dec.valid = 1'b1; dec.alu_op = 2'b10; dec.reg_write = 1'b1;
      end
      OP_I: begin
        dec.valid = 1'b1; dec.alu_op = 2'b11; dec.b_imm = 1'b1; dec.reg_write = 1'b1;
      end
      OP_LD: begin
        dec.valid = 1'b1; dec.b_imm = 1'b1; dec.mem_read = 1'b1;
        dec.reg_write = 1'b1; dec.res_src = 2'b01;
      end
      OP_ST: begin
        dec.valid = 1'b1; dec.b_imm = 1'b1; dec.mem_write = 1'b1; imm_src = 3'b001;
      end
      OP_BR: begin
        dec.valid = 1'b1; dec.alu_op = 2'b01; dec.branch = 1'b1; imm_src = 3'b010;
      end
      OP_JAL: begin
        dec.valid = 1'b1; dec.jump = 1'b1; dec.reg_write = 1'b1;
        dec.res_src = 2'b10; imm_src = 3'b011;
      end
      OP_JALR: begin
        if (EN_JALR) begin
          dec.valid = 1'b1; dec.b_imm = 1'b1; dec.jump = 1'b1; dec.jalr = 1'b1;
          dec.reg_write = 1'b1; dec.res_src = 2'b10;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_LUI: begin
        dec.valid = 1'b1; dec.reg_write = 1'b1; dec.res_src = 2'b11; imm_src = 3'b100;
      end
      OP_AUIPC: begin
        if (EN_AUIPC) begin
          dec.valid = 1'b1; dec.a_pc = 1'b1; dec.b_imm = 1'b1;
          dec.reg_write = 1'b1; imm_src = 3'b100;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      if (bus.stall || bus.flush || !bus.id_valid)
        ex_q <= '0;
      else
        ex_q <= dec;

      if (bus.flush)
        mem_q <= '0;
      else
        mem_q <= '{valid: ex_q.valid, mem_write: ex_q.mem_write, mem_read: ex_q.mem_read,
                   reg_write: ex_q.reg_write, res_src: ex_q.res_src};

      wb_q <= '{valid: mem_q.valid, reg_write: mem_q.reg_write, res_src: mem_q.res_src};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      ill_cnt_q <= '0;
    else if (ex_q.illegal && (ill_cnt_q != {ILL_CNT_W{1'b1}}))
      ill_cnt_q <= ill_cnt_q + 1'b1;
  end

  assign bus.id_imm_src    = imm_src;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_alu_op     = ex_q.alu_op;
  assign bus.ex_alu_a_pc   = ex_q.a_pc;
  assign bus.ex_alu_b_imm  = ex_q.b_imm;
  assign bus.ex_branch     = ex_q.branch;
  assign bus.ex_jump       = ex_q.jump;
  assign bus.ex_jalr       = ex_q.jalr;
  assign bus.ex_illegal    = ex_q.illegal;
  assign bus.mem_valid     = mem_q.valid;
  assign bus.mem_write     = mem_q.mem_write;
  assign bus.mem_read      = mem_q.mem_read;
  assign bus.wb_valid      = wb_q.valid;
  assign bus.wb_reg_write  = wb_q.reg_write;
  assign bus.wb_result_src = wb_q.res_src;
  assign bus.ill_count     = ill_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_decoder.sv
// Directed bench for ctrl_pipe_decoder: a default instance and a reduced one
// (JALR/AUIPC disabled, 2-bit illegal counter).
module tb_ctrl_pipe_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ctrl_pipe_decoder_if #(.ILL_CNT_W(8)) bus_a ();
  ctrl_pipe_decoder_if #(.ILL_CNT_W(2)) bus_b ();

  ctrl_pipe_decoder #(.EN_JALR(1'b1), .EN_AUIPC(1'b1), .ILL_CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  ctrl_pipe_decoder #(.EN_JALR(1'b0), .EN_AUIPC(1'b0), .ILL_CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  // ex view: {valid, alu_op[1:0], a_pc, b_imm, branch, jump, jalr, illegal}
  wire [8:0] ex_a  = {bus_a.ex_valid, bus_a.ex_alu_op, bus_a.ex_alu_a_pc, bus_a.ex_alu_b_imm,
                      bus_a.ex_branch, bus_a.ex_jump, bus_a.ex_jalr, bus_a.ex_illegal};
  wire [8:0] ex_b  = {bus_b.ex_valid, bus_b.ex_alu_op, bus_b.ex_alu_a_pc, bus_b.ex_alu_b_imm,
                      bus_b.ex_branch, bus_b.ex_jump, bus_b.ex_jalr, bus_b.ex_illegal};
  wire [2:0] mem_a = {bus_a.mem_valid, bus_a.mem_write, bus_a.mem_read};
  wire [2:0] mem_b = {bus_b.mem_valid, bus_b.mem_write, bus_b.mem_read};
  wire [3:0] wb_a  = {bus_a.wb_valid, bus_a.wb_reg_write, bus_a.wb_result_src};
  wire [3:0] wb_b  = {bus_b.wb_valid, bus_b.wb_reg_write, bus_b.wb_result_src};

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  localparam logic [8:0] EX_ILL = 9'b0_00_0_0_0_0_0_1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv_a(input logic v, input logic [6:0] op, input logic st, input logic fl);
    bus_a.id_valid = v; bus_a.op = op; bus_a.stall = st; bus_a.flush = fl;
  endtask

  task automatic drv_b(input logic v, input logic [6:0] op, input logic st, input logic fl);
    bus_b.id_valid = v; bus_b.op = op; bus_b.stall = st; bus_b.flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] ops   [9];
  logic [8:0] ex_e  [9];
  logic [2:0] mem_e [9];
  logic [3:0] wb_e  [9];
  logic [2:0] imm_e [9];

  initial begin
    ops[0] = OP_R;     ex_e[0] = 9'b1_10_0_0_0_0_0_0; mem_e[0] = 3'b100; wb_e[0] = 4'b1100; imm_e[0] = 3'b000;
    ops[1] = OP_I;     ex_e[1] = 9'b1_11_0_1_0_0_0_0; mem_e[1] = 3'b100; wb_e[1] = 4'b1100; imm_e[1] = 3'b000;
    ops[2] = OP_LD;    ex_e[2] = 9'b1_00_0_1_0_0_0_0; mem_e[2] = 3'b101; wb_e[2] = 4'b1101; imm_e[2] = 3'b000;
    ops[3] = OP_ST;    ex_e[3] = 9'b1_00_0_1_0_0_0_0; mem_e[3] = 3'b110; wb_e[3] = 4'b1000; imm_e[3] = 3'b001;
    ops[4] = OP_BR;    ex_e[4] = 9'b1_01_0_0_1_0_0_0; mem_e[4] = 3'b100; wb_e[4] = 4'b1000; imm_e[4] = 3'b010;
    ops[5] = OP_JAL;   ex_e[5] = 9'b1_00_0_0_0_1_0_0; mem_e[5] = 3'b100; wb_e[5] = 4'b1110; imm_e[5] = 3'b011;
    ops[6] = OP_JALR;  ex_e[6] = 9'b1_00_0_1_0_1_1_0; mem_e[6] = 3'b100; wb_e[6] = 4'b1110; imm_e[6] = 3'b000;
    ops[7] = OP_LUI;   ex_e[7] = 9'b1_00_0_0_0_0_0_0; mem_e[7] = 3'b100; wb_e[7] = 4'b1111; imm_e[7] = 3'b100;
    ops[8] = OP_AUIPC; ex_e[8] = 9'b1_00_1_1_0_0_0_0; mem_e[8] = 3'b100; wb_e[8] = 4'b1100; imm_e[8] = 3'b100;

    // reset with a store sitting in ID: registers stay empty, imm select still decodes
    drv_a(1'b1, OP_ST, 1'b0, 1'b0);
    drv_b(1'b0, 7'd0, 1'b0, 1'b0);
    tick(); tick();
    chk("rst_ex_a", 32'(ex_a), 32'd0);
    chk("rst_mem_a", 32'(mem_a), 32'd0);
    chk("rst_wb_a", 32'(wb_a), 32'd0);
    chk("rst_cnt_a", 32'(bus_a.ill_count), 32'd0);
    chk("rst_ex_b", 32'(ex_b), 32'd0);
    chk("rst_cnt_b", 32'(bus_b.ill_count), 32'd0);
    chk("rst_imm_comb", 32'(bus_a.id_imm_src), 32'd1);
    rst_n = 1'b1;

    // load latency through the pipe
    drv_a(1'b1, OP_LD, 1'b0, 1'b0);
    tick();
    chk("ld_ex", 32'(ex_a), 32'(ex_e[2]));
    drv_a(1'b0, 7'd0, 1'b0, 1'b0);
    tick();
    chk("ld_mem", 32'(mem_a), 32'b101);
    chk("ld_ex_empty", 32'(ex_a), 32'd0);
    tick();
    chk("ld_wb", 32'(wb_a), 32'b1101);
    chk("ld_mem_empty", 32'(mem_a), 32'd0);

    // every decode row back-to-back, then drain
    for (int i = 0; i < 12; i++) begin
      if (i < 9) begin
        drv_a(1'b1, ops[i], 1'b0, 1'b0);
        #1;
        chk($sformatf("b2b_imm_%0d", i), 32'(bus_a.id_imm_src), 32'(imm_e[i]));
      end else begin
        drv_a(1'b0, 7'd0, 1'b0, 1'b0);
      end
      tick();
      chk($sformatf("b2b_ex_%0d", i), 32'(ex_a), (i < 9) ? 32'(ex_e[i]) : 32'd0);
      chk($sformatf("b2b_mem_%0d", i), 32'(mem_a),
          (i >= 1 && i <= 9) ? 32'(mem_e[i-1]) : 32'd0);
      chk($sformatf("b2b_wb_%0d", i), 32'(wb_a),
          (i >= 2 && i <= 10) ? 32'(wb_e[i-2]) : 32'd0);
    end

    // load-use stall: bubble into EX, older instruction keeps moving
    drv_a(1'b1, OP_R, 1'b0, 1'b0);
    tick();
    drv_a(1'b1, OP_LD, 1'b1, 1'b0);
    tick();
    chk("stall_ex", 32'(ex_a), 32'd0);
    chk("stall_mem", 32'(mem_a), 32'b100);
    drv_a(1'b1, OP_LD, 1'b0, 1'b0);
    tick();
    chk("stall_rel_ex", 32'(ex_a), 32'(ex_e[2]));
    chk("stall_rel_mem", 32'(mem_a), 32'd0);
    chk("stall_rel_wb", 32'(wb_a), 32'b1100);
    drv_a(1'b0, 7'd0, 1'b0, 1'b0);
    tick(); tick(); tick();

    // flush with JAL in EX and ADD in ID; LUI in MEM must still retire
    drv_a(1'b1, OP_LUI, 1'b0, 1'b0);
    tick();
    drv_a(1'b1, OP_JAL, 1'b0, 1'b0);
    tick();
    drv_a(1'b1, OP_R, 1'b0, 1'b1);
    tick();
    chk("flush_ex", 32'(ex_a), 32'd0);
    chk("flush_mem", 32'(mem_a), 32'd0);
    chk("flush_wb", 32'(wb_a), 32'b1111);
    drv_a(1'b0, 7'd0, 1'b0, 1'b0);
    tick();
    chk("flush_wb_next", 32'(wb_a), 32'd0);

    // stall and flush together behave as flush
    drv_a(1'b1, OP_I, 1'b0, 1'b0);
    tick();
    drv_a(1'b1, OP_LD, 1'b1, 1'b1);
    tick();
    chk("stfl_ex", 32'(ex_a), 32'd0);
    chk("stfl_mem", 32'(mem_a), 32'd0);
    drv_a(1'b0, 7'd0, 1'b0, 1'b0);
    tick();
    chk("stfl_wb", 32'(wb_a), 32'd0);
    tick();

    // five illegal opcodes on both instances
    for (int k = 1; k <= 5; k++) begin
      drv_a(1'b1, OP_BAD, 1'b0, 1'b0);
      drv_b(1'b1, OP_BAD, 1'b0, 1'b0);
      #1;
      chk($sformatf("ill_imm_%0d", k), 32'(bus_a.id_imm_src), 32'd0);
      tick();
      chk($sformatf("ill_ex_a_%0d", k), 32'(ex_a), 32'(EX_ILL));
      chk($sformatf("ill_ex_b_%0d", k), 32'(ex_b), 32'(EX_ILL));
      chk($sformatf("ill_cnt_a_%0d", k), 32'(bus_a.ill_count), 32'(k - 1));
      chk($sformatf("ill_cnt_b_%0d", k), 32'(bus_b.ill_count), (k - 1 > 3) ? 32'd3 : 32'(k - 1));
      chk($sformatf("ill_mem_a_%0d", k), 32'(mem_a), 32'd0);
      chk($sformatf("ill_wb_a_%0d", k), 32'(wb_a), 32'd0);
    end
    drv_a(1'b0, 7'd0, 1'b0, 1'b0);
    drv_b(1'b0, 7'd0, 1'b0, 1'b0);
    tick();
    chk("ill_end_ex_b", 32'(ex_b), 32'd0);
    chk("ill_end_cnt_a", 32'(bus_a.ill_count), 32'd5);
    chk("ill_end_cnt_b", 32'(bus_b.ill_count), 32'd3);

    // illegal squashed by stall: no flag, no count
    drv_a(1'b1, OP_BAD, 1'b1, 1'b0);
    tick();
    chk("ill_stall_ex", 32'(ex_a), 32'd0);
    drv_a(1'b0, 7'd0, 1'b0, 1'b0);
    tick();
    chk("ill_stall_cnt", 32'(bus_a.ill_count), 32'd5);

    // JALR/AUIPC disabled on instance b
    drv_a(1'b1, OP_JALR, 1'b0, 1'b0);
    drv_b(1'b1, OP_JALR, 1'b0, 1'b0);
    #1;
    chk("dis_jalr_imm", 32'(bus_b.id_imm_src), 32'd0);
    tick();
    chk("dis_jalr_ex_b", 32'(ex_b), 32'(EX_ILL));
    chk("en_jalr_ex_a", 32'(ex_a), 32'(ex_e[6]));
    drv_a(1'b0, 7'd0, 1'b0, 1'b0);
    drv_b(1'b1, OP_AUIPC, 1'b0, 1'b0);
    #1;
    chk("dis_auipc_imm", 32'(bus_b.id_imm_src), 32'd0);
    tick();
    chk("dis_auipc_ex_b", 32'(ex_b), 32'(EX_ILL));
    chk("dis_cnt_b_sat", 32'(bus_b.ill_count), 32'd3);
    drv_b(1'b0, 7'd0, 1'b0, 1'b0);
    tick();
    chk("dis_mem_b", 32'(mem_b), 32'd0);
    tick();
    chk("dis_wb_b", 32'(wb_b), 32'd0);

    // reset in mid-stream
    drv_a(1'b1, OP_R, 1'b0, 1'b0);
    tick();
    drv_a(1'b1, OP_LD, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    drv_a(1'b1, OP_I, 1'b0, 1'b0);
    tick();
    chk("mrst_ex_a", 32'(ex_a), 32'd0);
    chk("mrst_mem_a", 32'(mem_a), 32'd0);
    chk("mrst_wb_a", 32'(wb_a), 32'd0);
    chk("mrst_cnt_a", 32'(bus_a.ill_count), 32'd0);
    chk("mrst_cnt_b", 32'(bus_b.ill_count), 32'd0);
    rst_n = 1'b1;
    drv_a(1'b0, 7'd0, 1'b0, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
